// File: rtl/route_decoder.sv
// Single-stage routing decoder: registers one flit, steers it to port 0 or 1 and
// emits a route-select token. Optional per-port retire counters under ROUTE_DECODER_STATS_EN.
module route_decoder #(
  parameter int                DATA_W    = 9,
  parameter int                ADDR_W    = 4,
  parameter int                ADDR_LSB  = 5,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b0010,
  parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1110,
  parameter int                LEAF      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              sel_data,
  output logic              sel_valid,
  input  logic              sel_ready
`ifdef ROUTE_DECODER_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);

  function automatic int count_ones(input logic [ADDR_W-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < ADDR_W; i++) n += int'(m[i]);
    return n;
  endfunction

  localparam int                K         = count_ones(NODE_MASK);
  localparam logic [ADDR_W-1:0] LEAD_ONES = ~({ADDR_W{1'b1}} >> K);
  localparam bit                MASK_OK   = (NODE_MASK == LEAD_ONES);
  // The tree bit is the first address bit below this node's prefix.
  localparam int                TREE_BIT  = (K < ADDR_W) ? (ADDR_W - 1 - K) : 0;

  generate
    if (!MASK_OK) begin : g_bad_mask
      $error("route_decoder: NODE_MASK must be contiguous leading ones");
    end
    if (LEAF == 0 && K == ADDR_W) begin : g_bad_tree
      $error("route_decoder: tree-bit mode needs a NODE_MASK with at least one zero");
    end
    if (ADDR_LSB + ADDR_W > DATA_W) begin : g_bad_field
      $error("route_decoder: address field exceeds flit width");
    end
  endgenerate

  typedef enum logic [1:0] {EMPTY, FULL, WAIT_DATA, WAIT_SEL} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic                r_route;
  logic                r_out0_valid;
  logic                r_out1_valid;
  logic                r_sel_valid;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_route;
  logic                w_data_hs;
  logic                w_sel_hs;
  logic                w_retire;
  logic                w_accept;

  assign w_addr  = in_data[ADDR_LSB +: ADDR_W];
  assign w_route = (LEAF != 0) ? ((w_addr & NODE_MASK) != NODE_ADDR) : w_addr[TREE_BIT];

  assign w_data_hs = (r_out0_valid & out0_ready) | (r_out1_valid & out1_ready);
  assign w_sel_hs  = r_sel_valid & sel_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      FULL:      w_retire = w_data_hs & w_sel_hs;
      WAIT_DATA: w_retire = w_data_hs;
      WAIT_SEL:  w_retire = w_sel_hs;
      default:   w_retire = 1'b0;
    endcase
  end

  assign in_ready = ~reset & ((r_state == EMPTY) | w_retire);
  assign w_accept = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments; later assignments in the
  // same block take priority, so accept overrides retire, which overrides partial progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the flit register is reset too, so outputs read 0 rather than stale data after reset.
      r_state      <= EMPTY;
      r_data       <= '0;
      r_route      <= 1'b0;
      r_out0_valid <= 1'b0;
      r_out1_valid <= 1'b0;
      r_sel_valid  <= 1'b0;
    end else begin
      if (r_state == FULL && w_data_hs && !w_sel_hs) begin
        r_state      <= WAIT_SEL;
        r_out0_valid <= 1'b0;
        r_out1_valid <= 1'b0;
      end else if (r_state == FULL && w_sel_hs && !w_data_hs) begin
        r_state     <= WAIT_DATA;
        r_sel_valid <= 1'b0;
      end
      if (w_retire) begin
        r_state      <= EMPTY;
        r_out0_valid <= 1'b0;
        r_out1_valid <= 1'b0;
        r_sel_valid  <= 1'b0;
      end
      if (w_accept) begin
        r_state      <= FULL;
        r_data       <= in_data;
        r_route      <= w_route;
        r_out0_valid <= ~w_route;
        r_out1_valid <= w_route;
        r_sel_valid  <= 1'b1;
      end
    end
  end

  assign out0_data  = r_data;
  assign out1_data  = r_data;
  assign out0_valid = r_out0_valid;
  assign out1_valid = r_out1_valid;
  assign sel_data   = r_route;
  assign sel_valid  = r_sel_valid;

`ifdef ROUTE_DECODER_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_retire) begin
      if (r_route) r_cnt1 <= r_cnt1 + 16'd1;
      else         r_cnt0 <= r_cnt0 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_route_decoder.sv
// Bench for route_decoder: a tree-mode and a leaf-mode instance share stimulus and are
// compared every cycle against a transaction-level model of the pending flit.
module tb_route_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] in_data;
  logic       in_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic       sel_ready;

  logic [8:0] o0d [2];
  logic [8:0] o1d [2];
  logic       o0v [2];
  logic       o1v [2];
  logic       sv  [2];
  logic       sd  [2];
  logic       ir  [2];
`ifdef ROUTE_DECODER_STATS_EN
  logic [15:0] c0 [2];
  logic [15:0] c1 [2];
`endif

  int total = 0;
  int bad   = 0;

  // Model of the single pending flit per instance.
  bit         m_pend [2] = '{0, 0};
  bit         m_dd   [2] = '{0, 0};
  bit         m_sd   [2] = '{0, 0};
  logic [8:0] m_data [2] = '{9'd0, 9'd0};
  bit         m_port [2] = '{0, 0};
  logic [15:0] m_c0  [2] = '{16'd0, 16'd0};
  logic [15:0] m_c1  [2] = '{16'd0, 16'd0};
  int         m_ret  [2] = '{0, 0};

  always #5 clk = ~clk;

  route_decoder u_tree (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .out0_data(o0d[0]), .out0_valid(o0v[0]), .out0_ready(out0_ready),
    .out1_data(o1d[0]), .out1_valid(o1v[0]), .out1_ready(out1_ready),
    .sel_data(sd[0]), .sel_valid(sv[0]), .sel_ready(sel_ready)
`ifdef ROUTE_DECODER_STATS_EN
    , .cnt0(c0[0]), .cnt1(c1[0])
`endif
  );

  route_decoder #(.LEAF(1)) u_leaf (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .out0_data(o0d[1]), .out0_valid(o0v[1]), .out0_ready(out0_ready),
    .out1_data(o1d[1]), .out1_valid(o1v[1]), .out1_ready(out1_ready),
    .sel_data(sd[1]), .sel_valid(sv[1]), .sel_ready(sel_ready)
`ifdef ROUTE_DECODER_STATS_EN
    , .cnt0(c0[1]), .cnt1(c1[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Node 0010/1110 sits at tree level 3: leaf mode matches the prefix, tree mode splits on A[0].
  function automatic bit model_route(input int inst, input logic [8:0] flit);
    logic [3:0] a;
    a = flit[8:5];
    if (inst == 1) return ((a & 4'b1110) == 4'b0010) ? 1'b0 : 1'b1;
    return a[0];
  endfunction

  task automatic model_cycle(input int i);
    bit    ev0, ev1, evs, dhs, shs, ret, eir;
    string nm;
    nm  = (i == 1) ? "leaf" : "tree";
    ev0 = m_pend[i] && !m_dd[i] && (m_port[i] == 1'b0);
    ev1 = m_pend[i] && !m_dd[i] && (m_port[i] == 1'b1);
    evs = m_pend[i] && !m_sd[i];
    dhs = (ev0 && out0_ready) || (ev1 && out1_ready);
    shs = evs && sel_ready;
    ret = m_pend[i] && (m_dd[i] || dhs) && (m_sd[i] || shs);
    eir = !reset && (!m_pend[i] || ret);
    chk({nm, ".out0_valid"}, 32'(o0v[i]), 32'(ev0));
    chk({nm, ".out1_valid"}, 32'(o1v[i]), 32'(ev1));
    chk({nm, ".sel_valid"},  32'(sv[i]),  32'(evs));
    chk({nm, ".in_ready"},   32'(ir[i]),  32'(eir));
    if (ev0) chk({nm, ".out0_data"}, 32'(o0d[i]), 32'(m_data[i]));
    if (ev1) chk({nm, ".out1_data"}, 32'(o1d[i]), 32'(m_data[i]));
    if (evs) chk({nm, ".sel_data"},  32'(sd[i]),  32'(m_port[i]));
`ifdef ROUTE_DECODER_STATS_EN
    chk({nm, ".cnt0"}, 32'(c0[i]), 32'(m_c0[i]));
    chk({nm, ".cnt1"}, 32'(c1[i]), 32'(m_c1[i]));
`endif
    if (reset) begin
      m_pend[i] = 1'b0;
      m_c0[i]   = 16'd0;
      m_c1[i]   = 16'd0;
    end else begin
      if (ret) begin
        m_pend[i] = 1'b0;
        m_ret[i]++;
        if (m_port[i]) m_c1[i] = m_c1[i] + 16'd1;
        else           m_c0[i] = m_c0[i] + 16'd1;
      end else begin
        if (dhs) m_dd[i] = 1'b1;
        if (shs) m_sd[i] = 1'b1;
      end
      if (in_valid && eir) begin
        m_pend[i] = 1'b1;
        m_dd[i]   = 1'b0;
        m_sd[i]   = 1'b0;
        m_data[i] = in_data;
        m_port[i] = model_route(i, in_data);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit r0, input bit r1, input bit rs);
    out0_ready = r0;
    out1_ready = r1;
    sel_ready  = rs;
  endtask

  initial begin
    int base;
    logic [8:0] f_wait;

    reset = 1'b1; in_valid = 1'b0; in_data = 9'd0;
    set_ready(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    sample();
    chk("reset.in_ready_low", 32'(ir[0]), 32'd0);
    advance();
    reset = 1'b0;
    sample();
    chk("reset.in_ready_high", 32'(ir[0]), 32'd1);
    chk("reset.out0_data_zero", 32'(o0d[0]), 32'd0);
    chk("reset.out1_data_zero", 32'(o1d[1]), 32'd0);
    advance();

    // Default tree node, flit with A=0000: port 0, token 0.
    set_ready(1'b1, 1'b1, 1'b1);
    in_valid = 1'b1; in_data = 9'b0_0000_0000;
    sample(); advance();
    in_valid = 1'b0;
    sample();
    chk("basic.out0_valid", 32'(o0v[0]), 32'd1);
    chk("basic.sel_data", 32'(sd[0]), 32'd0);
    chk("basic.in_ready", 32'(ir[0]), 32'd1);
    advance();

    // Leaf matching: A=0011 hits the node, A=0100 does not.
    in_valid = 1'b1; in_data = {4'b0011, 5'h03};
    sample(); advance();
    in_data = {4'b0100, 5'h14};
    sample();
    chk("leaf_hit.out0_valid", 32'(o0v[1]), 32'd1);
    chk("leaf_hit.sel_data", 32'(sd[1]), 32'd0);
    advance();
    in_valid = 1'b0;
    sample();
    chk("leaf_miss.out1_valid", 32'(o1v[1]), 32'd1);
    chk("leaf_miss.sel_data", 32'(sd[1]), 32'd1);
    advance();

    // Token taken first, data held off for three cycles.
    f_wait = {4'b0001, 5'h0A};
    set_ready(1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = f_wait;
    sample(); advance();
    in_data = {4'b1011, 5'h15};
    sample(); advance();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("wait_data.sel_valid", 32'(sv[0]), 32'd0);
      chk("wait_data.out1_valid", 32'(o1v[0]), 32'd1);
      chk("wait_data.out1_data", 32'(o1d[0]), 32'(f_wait));
      chk("wait_data.in_ready", 32'(ir[0]), 32'd0);
      advance();
    end
    out1_ready = 1'b1;
    sample(); advance();
    in_valid = 1'b0; set_ready(1'b1, 1'b1, 1'b1);
    sample(); advance();

    // Eight back-to-back flits.
    base = m_ret[0];
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = 9'($urandom);
      sample(); advance();
    end
    in_valid = 1'b0;
    sample(); advance();
    chk("b2b.retired", 32'(m_ret[0] - base), 32'd8);

    // Reset while a flit is pending.
    set_ready(1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = {4'b0110, 5'h07};
    sample(); advance();
    in_valid = 1'b0;
    sample(); advance();
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    sample();
    chk("rst_full.out0_valid", 32'(o0v[0]), 32'd0);
    chk("rst_full.out1_valid", 32'(o1v[0]), 32'd0);
    chk("rst_full.sel_valid", 32'(sv[0]), 32'd0);
    chk("rst_full.in_ready", 32'(ir[0]), 32'd1);
`ifdef ROUTE_DECODER_STATS_EN
    chk("rst_full.cnt0", 32'(c0[0]), 32'd0);
    chk("rst_full.cnt1", 32'(c1[0]), 32'd0);
`endif
    advance();

    // Random traffic with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 9'($urandom);
      set_ready($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      sample(); advance();
    end
    in_valid = 1'b0; set_ready(1'b1, 1'b1, 1'b1);
    repeat (3) begin sample(); advance(); end

`ifdef ROUTE_DECODER_STATS_EN
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    in_valid = 1'b1; in_data = {4'b0001, 5'h1F};
    for (int n = 0; n < 65537; n++) begin
      sample(); advance();
    end
    in_valid = 1'b0;
    sample(); advance();
    sample();
    chk("wrap.tree_cnt1", 32'(c1[0]), 32'd1);
    chk("wrap.tree_cnt0", 32'(c0[0]), 32'd0);
    chk("wrap.leaf_cnt1", 32'(c1[1]), 32'd1);
    chk("wrap.leaf_cnt0", 32'(c0[1]), 32'd0);
    advance();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
